// File: rtl/alucomm_ram.sv
// Operand/result scratch RAM serving the crypto ALU RAM port, a 32-bit host port
// for operand load/result unload, and a sequencer that zeroes the array between runs.
module alucomm_ram #(
  parameter int DW  = 64,
  parameter int LW  = 4096,
  parameter int RAW = $clog2(LW / DW) + 2,
  parameter int HW  = 32,
  parameter int HAW = RAW + $clog2(DW / HW)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           alu_busy,
  input  logic [RAW-1:0] ramaddr,
  input  logic           ramrd,
  input  logic           ramwr,
  input  logic [DW-1:0]  ramwdat,
  output logic [DW-1:0]  ramrdat,
  input  logic           hreq,
  input  logic           hwr,
  input  logic [HAW-1:0] haddr,
  input  logic [HW-1:0]  hwdat,
  output logic           hrdy,
  output logic           hrvalid,
  output logic [HW-1:0]  hrdat,
  input  logic           clr_start,
  output logic           clr_busy,
  output logic           err
);

  localparam int LSW   = HAW - RAW;
  localparam int HBW   = $clog2(HW);
  localparam int DEPTH = 2 ** RAW;

  typedef enum logic {
    IDLE,
    CLR
  } state_t;

  state_t         state, state_nxt;
  logic [RAW-1:0] clr_cnt, clr_cnt_nxt;

  logic [DW-1:0]  mem [DEPTH];

  logic           idle;
  logic           alu_rd;
  logic           alu_wr;
  logic           host_acc;
  logic           host_wr;
  logic           host_rd;
  logic           alu_in_clr;
  logic [RAW-1:0] host_word;
  logic [LSW+HBW-1:0] lane_base;

  assign idle       = (state == IDLE);
  assign alu_rd     = idle & ramrd;
  assign alu_wr     = idle & ramwr;
  // Host yields to any ALU strobe so the array never needs two ports.
  assign host_acc   = hreq & ~alu_busy & idle & ~ramrd & ~ramwr & ~reset;
  assign host_wr    = host_acc & hwr;
  assign host_rd    = host_acc & ~hwr;
  assign hrdy       = host_acc;
  assign host_word  = haddr[HAW-1:LSW];
  assign lane_base  = {haddr[LSW-1:0], {HBW{1'b0}}};
  assign alu_in_clr = ~idle & (ramrd | ramwr | alu_busy);
  assign clr_busy   = ~idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_start && !alu_busy) begin
          state_nxt   = CLR;
          clr_cnt_nxt = '0;
        end
      end
      CLR: begin
        // Counter wraps to zero on the final word, ready for the next clear.
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == {RAW{1'b1}}) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Array write port: clear, ALU and host writes are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[clr_cnt] <= '0;
    end else if (alu_wr) begin
      mem[ramaddr] <= ramwdat;
    end else if (host_wr) begin
      mem[host_word][lane_base +: HW] <= hwdat;
    end
  end

  // Read data registers hold between reads; the ALU relies on ramrdat holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramrdat <= '0;
      hrdat   <= '0;
      hrvalid <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (alu_rd) begin
        ramrdat <= mem[ramaddr];
      end
      if (host_rd) begin
        hrdat <= mem[host_word][lane_base +: HW];
      end
      hrvalid <= host_rd;
      if (alu_in_clr) begin
        err <= 1'b1;
      end
    end
  end

endmodule
